// File: rtl/if_fetch_unit_if.sv
// Bus bundle for the instruction-fetch front end: memory request/response
// channel plus the redirect/stall controls and the IF/ID-facing outputs.
interface if_fetch_unit_if;
    logic [31:0] iad;
    logic        ireq;
    logic        igrant;
    logic [31:0] idt;
    logic        ivalid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic        valid_out;

    modport master (
        output iad, ireq, inst_out, pc_out, pc4_out, valid_out,
        input  igrant, idt, ivalid, redirect, redirect_pc, stall
    );

    modport slave (
        input  iad, ireq, inst_out, pc_out, pc4_out, valid_out,
        output igrant, idt, ivalid, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: credit-limited memory requests, an in-order PC
// queue matched to responses, and a small {pc, inst} buffer feeding IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fetch_pc_r, fetch_pc_n_s;
    logic [31:0]      fifo_pc_r   [FIFO_DEPTH];
    logic [31:0]      fifo_inst_r [FIFO_DEPTH];
    logic [31:0]      pcq_r       [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_n_s, wr_ptr_r, wr_ptr_n_s;
    logic [PTR_W-1:0] pcq_rd_r, pcq_rd_n_s, pcq_wr_r, pcq_wr_n_s;
    logic [CNT_W-1:0] count_r, count_n_s;
    logic [CNT_W-1:0] outstanding_r, outstanding_n_s;
    logic [CNT_W-1:0] drop_r, drop_n_s;

    logic             credit_ok_s;
    logic             ireq_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             head_valid_s;
    logic             redirect_pc_unused_s;

    assign redirect_pc_unused_s = ^bus.redirect_pc[1:0];

    // Stale requests still in flight consume credit until their responses drain.
    assign credit_ok_s  = ({1'b0, outstanding_r} + {1'b0, count_r}) < DEPTH_C;
    assign ireq_s       = ~rst & ~bus.redirect & credit_ok_s;
    assign accept_s     = ireq_s & bus.igrant;
    assign head_valid_s = (count_r != CNT_W'(0));
    assign pop_s        = head_valid_s & ~bus.stall;

    assign bus.ireq      = ireq_s;
    assign bus.iad       = fetch_pc_r;
    assign bus.valid_out = head_valid_s;
    assign bus.inst_out  = head_valid_s ? fifo_inst_r[rd_ptr_r] : NOP_INST;
    assign bus.pc_out    = head_valid_s ? fifo_pc_r[rd_ptr_r] : 32'h0000_0000;
    assign bus.pc4_out   = head_valid_s ? (fifo_pc_r[rd_ptr_r] + 32'h0000_0004) : 32'h0000_0004;

    // Next-state logic; a redirect overrides stall, push and pop.
    always_comb begin
        fetch_pc_n_s    = fetch_pc_r;
        rd_ptr_n_s      = rd_ptr_r;
        wr_ptr_n_s      = wr_ptr_r;
        pcq_rd_n_s      = pcq_rd_r;
        pcq_wr_n_s      = pcq_wr_r;
        count_n_s       = count_r;
        outstanding_n_s = outstanding_r - CNT_W'(bus.ivalid);
        drop_n_s        = drop_r;
        push_s          = 1'b0;
        if (bus.redirect) begin
            fetch_pc_n_s = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_n_s   = PTR_W'(0);
            wr_ptr_n_s   = PTR_W'(0);
            pcq_rd_n_s   = PTR_W'(0);
            pcq_wr_n_s   = PTR_W'(0);
            count_n_s    = CNT_W'(0);
            // Everything still in flight after this edge belongs to the wrong path.
            drop_n_s     = outstanding_r - CNT_W'(bus.ivalid);
        end else begin
            if (accept_s) begin
                fetch_pc_n_s    = fetch_pc_r + 32'h0000_0004;
                pcq_wr_n_s      = pcq_wr_r + PTR_W'(1);
                outstanding_n_s = outstanding_r + CNT_W'(1) - CNT_W'(bus.ivalid);
            end else begin
                outstanding_n_s = outstanding_r - CNT_W'(bus.ivalid);
            end
            if (bus.ivalid) begin
                if (drop_r != CNT_W'(0)) begin
                    drop_n_s = drop_r - CNT_W'(1);
                end else begin
                    push_s     = 1'b1;
                    pcq_rd_n_s = pcq_rd_r + PTR_W'(1);
                    wr_ptr_n_s = wr_ptr_r + PTR_W'(1);
                end
            end else begin
                drop_n_s = drop_r;
            end
            if (pop_s) begin
                rd_ptr_n_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_n_s = rd_ptr_r;
            end
            count_n_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            rd_ptr_r      <= PTR_W'(0);
            wr_ptr_r      <= PTR_W'(0);
            pcq_rd_r      <= PTR_W'(0);
            pcq_wr_r      <= PTR_W'(0);
            count_r       <= CNT_W'(0);
            outstanding_r <= CNT_W'(0);
            drop_r        <= CNT_W'(0);
        end else begin
            fetch_pc_r    <= fetch_pc_n_s;
            rd_ptr_r      <= rd_ptr_n_s;
            wr_ptr_r      <= wr_ptr_n_s;
            pcq_rd_r      <= pcq_rd_n_s;
            pcq_wr_r      <= pcq_wr_n_s;
            count_r       <= count_n_s;
            outstanding_r <= outstanding_n_s;
            drop_r        <= drop_n_s;
        end
    end

    // Data storage: PC captured at accept, {pc, inst} written on a kept response.
    always_ff @(posedge clk) begin
        if (!rst && accept_s) begin
            pcq_r[pcq_wr_r] <= fetch_pc_r;
        end
        if (!rst && push_s) begin
            fifo_pc_r[wr_ptr_r]   <= pcq_r[pcq_rd_r];
            fifo_inst_r[wr_ptr_r] <= bus.idt;
        end
    end
endmodule
